// File: rtl/lsu.sv
// Load/store unit: turns core byte/half/word requests into word-aligned data-memory
// accesses with byte enables, extends load data, and stalls the core one cycle per load.
module lsu (
    input  logic        clk_i,
    input  logic        arstn_i,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [2:0]  lsu_size_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_data_i,
    output logic [31:0] lsu_data_o,
    output logic        lsu_stall_o,
    output logic        lsu_misalign_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i
);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] data_reg, data_next;

    logic        size_ok;
    logic        align_ok;
    logic        legal;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] shifted;
    logic [31:0] extracted;

    // Legality: only B/H/W/BU/HU exist, unsigned sizes are load-only, natural alignment.
    always_comb begin
        size_ok = 1'b0;
        case (lsu_size_i)
            3'b000, 3'b001, 3'b010: size_ok = 1'b1;
            3'b100, 3'b101:         size_ok = !lsu_we_i;
            default:                size_ok = 1'b0;
        endcase
        align_ok = 1'b1;
        case (lsu_size_i[1:0])
            2'b01:   align_ok = !lsu_addr_i[0];
            2'b10:   align_ok = (lsu_addr_i[1:0] == 2'b00);
            default: align_ok = 1'b1;
        endcase
        legal = size_ok && align_ok;
    end

    always_comb begin
        be = 4'b1111;
        wd = lsu_data_i;
        case (lsu_size_i[1:0])
            2'b00: begin
                be = 4'b0001 << lsu_addr_i[1:0];
                wd = {4{lsu_data_i[7:0]}};
            end
            2'b01: begin
                be = lsu_addr_i[1] ? 4'b1100 : 4'b0011;
                wd = {2{lsu_data_i[15:0]}};
            end
            default: begin
                be = 4'b1111;
                wd = lsu_data_i;
            end
        endcase
    end

    // Bring the addressed lane down to bit 0, then extend by access type.
    always_comb begin
        shifted   = mem_rd_i >> {lsu_addr_i[1:0], 3'b000};
        extracted = shifted;
        case (lsu_size_i)
            3'b000:  extracted = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  extracted = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  extracted = {24'd0, shifted[7:0]};
            3'b101:  extracted = {16'd0, shifted[15:0]};
            default: extracted = shifted;
        endcase
    end

    always_comb begin
        state_next     = state_reg;
        data_next      = data_reg;
        lsu_stall_o    = 1'b0;
        lsu_misalign_o = 1'b0;
        mem_req_o      = 1'b0;
        mem_we_o       = 1'b0;
        mem_be_o       = 4'b0000;
        mem_addr_o     = 32'd0;
        mem_wd_o       = 32'd0;
        case (state_reg)
            IDLE: begin
                if (lsu_req_i) begin
                    if (!legal) begin
                        lsu_misalign_o = 1'b1;
                    end else begin
                        mem_req_o  = 1'b1;
                        mem_we_o   = lsu_we_i;
                        mem_be_o   = be;
                        mem_addr_o = {lsu_addr_i[31:2], 2'b00};
                        if (lsu_we_i) begin
                            mem_wd_o = wd;
                        end else begin
                            lsu_stall_o = 1'b1;
                            data_next   = extracted;
                            state_next  = RESP;
                        end
                    end
                end
            end
            // The core still presents the finished load here; it must not be reissued.
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_reg <= IDLE;
            data_reg  <= 32'd0;
        end else begin
            state_reg <= state_next;
            data_reg  <= data_next;
        end
    end

    assign lsu_data_o = data_reg;

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed cases then random requests, checked against a byte-addressed
// reference memory and access rules computed arithmetically.
module tb_lsu;

    logic        clk_i = 1'b0;
    logic        arstn_i;
    logic        lsu_req_i;
    logic        lsu_we_i;
    logic [2:0]  lsu_size_i;
    logic [31:0] lsu_addr_i;
    logic [31:0] lsu_data_i;
    logic [31:0] lsu_data_o;
    logic        lsu_stall_o;
    logic        lsu_misalign_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  ref_mem [64];
    logic [31:0] dm [16];
    logic [31:0] exp_data;

    always #5 clk_i = ~clk_i;

    lsu dut (
        .clk_i          (clk_i),
        .arstn_i        (arstn_i),
        .lsu_req_i      (lsu_req_i),
        .lsu_we_i       (lsu_we_i),
        .lsu_size_i     (lsu_size_i),
        .lsu_addr_i     (lsu_addr_i),
        .lsu_data_i     (lsu_data_i),
        .lsu_data_o     (lsu_data_o),
        .lsu_stall_o    (lsu_stall_o),
        .lsu_misalign_o (lsu_misalign_o),
        .mem_req_o      (mem_req_o),
        .mem_we_o       (mem_we_o),
        .mem_be_o       (mem_be_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wd_o       (mem_wd_o),
        .mem_rd_i       (mem_rd_i)
    );

    // Data memory the DUT talks to: combinational read, byte-enabled write at the edge.
    assign mem_rd_i = dm[mem_addr_o[5:2]];
    always @(posedge clk_i) begin
        if (mem_req_o && mem_we_o) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_be_o[b]) dm[mem_addr_o[5:2]][8*b +: 8] <= mem_wd_o[8*b +: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [2:0] size);
        case (size[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit ref_legal(input logic we, input logic [2:0] size, input logic [31:0] addr);
        if (size == 3'b011 || size == 3'b110 || size == 3'b111) return 1'b0;
        if (we && size[2]) return 1'b0;
        return (int'(addr[1:0]) % nbytes(size)) == 0;
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] size, input logic [31:0] addr);
        logic [3:0] mask;
        mask = 4'((1 << nbytes(size)) - 1);
        return mask << addr[1:0];
    endfunction

    function automatic logic [31:0] ref_wd(input logic [2:0] size, input logic [31:0] data);
        logic [31:0] v;
        int n;
        n = nbytes(size);
        for (int i = 0; i < 4; i++) v[8*i +: 8] = data[8*(i % n) +: 8];
        return v;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] size, input logic [31:0] addr);
        logic [31:0] v;
        int n;
        n = nbytes(size);
        v = 32'd0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[int'(addr[5:0]) + i];
        if (!size[2] && n < 4 && v[8*n-1]) begin
            for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
        end
        return v;
    endfunction

    // One request; leaves the DUT back in IDLE just after a rising edge.
    task automatic op(input logic we, input logic [2:0] size, input logic [31:0] addr,
                      input logic [31:0] data);
        bit legal;
        legal = ref_legal(we, size, addr);
        @(negedge clk_i);
        lsu_req_i  = 1'b1;
        lsu_we_i   = we;
        lsu_size_i = size;
        lsu_addr_i = addr;
        lsu_data_i = data;
        #1;
        $display("op we=%0d size=%03b addr=0x%08h data=0x%08h legal=%0d", we, size, addr, data, legal);
        if (!legal) begin
            chk("illegal misalign", 32'(lsu_misalign_o), 32'd1);
            chk("illegal mem_req", 32'(mem_req_o), 32'd0);
            chk("illegal mem_we", 32'(mem_we_o), 32'd0);
            chk("illegal stall", 32'(lsu_stall_o), 32'd0);
            @(posedge clk_i); #1;
            chk("illegal data kept", lsu_data_o, exp_data);
        end else if (we) begin
            chk("store misalign", 32'(lsu_misalign_o), 32'd0);
            chk("store mem_req", 32'(mem_req_o), 32'd1);
            chk("store mem_we", 32'(mem_we_o), 32'd1);
            chk("store stall", 32'(lsu_stall_o), 32'd0);
            chk("store be", 32'(mem_be_o), 32'(ref_be(size, addr)));
            chk("store wd", mem_wd_o, ref_wd(size, data));
            chk("store addr", mem_addr_o, {addr[31:2], 2'b00});
            for (int i = 0; i < nbytes(size); i++)
                ref_mem[int'(addr[5:0]) + i] = data[8*i +: 8];
            @(posedge clk_i); #1;
            chk("store data kept", lsu_data_o, exp_data);
        end else begin
            chk("load misalign", 32'(lsu_misalign_o), 32'd0);
            chk("load mem_req", 32'(mem_req_o), 32'd1);
            chk("load mem_we", 32'(mem_we_o), 32'd0);
            chk("load stall T", 32'(lsu_stall_o), 32'd1);
            chk("load be", 32'(mem_be_o), 32'(ref_be(size, addr)));
            chk("load addr", mem_addr_o, {addr[31:2], 2'b00});
            exp_data = ref_load(size, addr);
            @(posedge clk_i); #1;
            chk("load stall T+1", 32'(lsu_stall_o), 32'd0);
            chk("load no reissue", 32'(mem_req_o), 32'd0);
            chk("load data", lsu_data_o, exp_data);
            @(posedge clk_i);
        end
    endtask

    task automatic idle_cycle();
        @(negedge clk_i);
        lsu_req_i  = 1'b0;
        lsu_we_i   = 1'($urandom_range(0, 1));
        lsu_size_i = 3'($urandom_range(0, 7));
        lsu_addr_i = $urandom;
        lsu_data_i = $urandom;
        #1;
        chk("idle outputs", {25'd0, mem_req_o, mem_we_o, mem_be_o, lsu_stall_o},
            32'd0);
        chk("idle misalign", 32'(lsu_misalign_o), 32'd0);
        chk("idle addr/wd", mem_addr_o | mem_wd_o, 32'd0);
        @(posedge clk_i);
    endtask

    initial begin
        logic        r_we;
        logic [2:0]  r_size;
        logic [31:0] r_addr;

        for (int i = 0; i < 64; i++) ref_mem[i] = 8'($urandom);
        for (int w = 0; w < 16; w++)
            dm[w] = {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
        exp_data   = 32'd0;
        arstn_i    = 1'b0;
        lsu_req_i  = 1'b0;
        lsu_we_i   = 1'b0;
        lsu_size_i = 3'b000;
        lsu_addr_i = 32'd0;
        lsu_data_i = 32'd0;
        #12;
        chk("reset data", lsu_data_o, 32'd0);
        chk("reset stall", 32'(lsu_stall_o), 32'd0);
        chk("reset mem_req", 32'(mem_req_o), 32'd0);
        @(negedge clk_i);
        arstn_i = 1'b1;

        op(1'b1, 3'b000, 32'h06, 32'h0000_00A5);
        op(1'b1, 3'b010, 32'h08, 32'h80F0_1234);
        op(1'b0, 3'b000, 32'h0B, 32'h0);
        chk("LB 0x0B", lsu_data_o, 32'hFFFF_FF80);
        op(1'b0, 3'b100, 32'h0B, 32'h0);
        chk("LBU 0x0B", lsu_data_o, 32'h0000_0080);
        op(1'b0, 3'b001, 32'h0A, 32'h0);
        chk("LH 0x0A", lsu_data_o, 32'hFFFF_80F0);
        op(1'b0, 3'b010, 32'h08, 32'h0);
        chk("LW 0x08", lsu_data_o, 32'h80F0_1234);
        op(1'b0, 3'b010, 32'h0A, 32'h0);
        op(1'b1, 3'b001, 32'h03, 32'hDEAD_BEEF);
        op(1'b1, 3'b101, 32'h04, 32'h1111_2222);
        op(1'b0, 3'b011, 32'h04, 32'h0);
        op(1'b1, 3'b010, 32'h10, 32'h1234_5678);
        op(1'b0, 3'b010, 32'h10, 32'h0);
        chk("SW/LW 0x10", lsu_data_o, 32'h1234_5678);
        idle_cycle();

        // Reset during the stall cycle of a load: nothing captured, no RESP afterwards.
        @(negedge clk_i);
        lsu_req_i  = 1'b1;
        lsu_we_i   = 1'b0;
        lsu_size_i = 3'b010;
        lsu_addr_i = 32'h08;
        #1;
        chk("rst-load stall", 32'(lsu_stall_o), 32'd1);
        #2 arstn_i = 1'b0;
        #1;
        chk("rst-load async clear", lsu_data_o, 32'd0);
        @(posedge clk_i); #1;
        chk("rst-load still IDLE", 32'(lsu_stall_o), 32'd1);
        chk("rst-load no capture", lsu_data_o, 32'd0);
        @(negedge clk_i);
        lsu_req_i = 1'b0;
        arstn_i   = 1'b1;
        #1;
        chk("rst-load released data", lsu_data_o, 32'd0);
        chk("rst-load released stall", 32'(lsu_stall_o), 32'd0);
        exp_data = 32'd0;
        @(posedge clk_i);

        for (int n = 0; n < 300; n++) begin
            r_we   = 1'($urandom_range(0, 1));
            r_size = 3'($urandom_range(0, 7));
            r_addr = $urandom;
            if ($urandom_range(0, 3) != 0) r_addr = r_addr & ~32'(nbytes(r_size) - 1);
            op(r_we, r_size, r_addr, $urandom);
            if ($urandom_range(0, 7) == 0) idle_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit between the core's execute stage and the data memory `dm`. It converts core memory requests (byte, halfword, word; signed and unsigned loads) into word-aligned data-memory accesses with byte enables. It also sign- or zero-extends load data and stalls the core for one cycle on every load. Misaligned or illegal requests are detected and never reach memory.

## Interface
Parameters:
- none

Ports (clock and reset first):
- `clk_i`  in  1  system clock, rising edge
- `arstn_i`  in  1  asynchronous active-low reset
- `lsu_req_i`  in  1  core memory request valid; held stable while `lsu_stall_o`=1
- `lsu_we_i`  in  1  1 = store, 0 = load
- `lsu_size_i`  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- `lsu_addr_i`  in  32  byte address
- `lsu_data_i`  in  32  store data, right-aligned
- `lsu_data_o`  out  32  load result, extended; registered
- `lsu_stall_o`  out  1  core must hold its pipeline
- `lsu_misalign_o`  out  1  request misaligned or illegal; not performed
- `mem_req_o`  out  1  memory access valid
- `mem_we_o`  out  1  memory write enable
- `mem_be_o`  out  4  byte enables, bit n = byte n
- `mem_addr_o`  out  32  `{lsu_addr_i[31:2],2'b00}`
- `mem_wd_o`  out  32  lane-replicated write data
- `mem_rd_i`  in  32  memory read word; combinational for the current `mem_addr_o`

## Operation
- FSM states:
  - IDLE (reset state).
  - RESP (load result registered, core released).
- Legality check:
  - Illegal when `lsu_addr_i[0]`=1 for H/HU.
  - Illegal when `lsu_addr_i[1:0]`≠0 for W.
  - Illegal for `lsu_size_i` ∈ {011,110,111}.
  - Illegal for stores with BU/HU.
- Illegal request in IDLE:
  - `lsu_misalign_o`=1; `mem_req_o`=0 and `mem_we_o`=0; `lsu_stall_o`=0.
  - State and `lsu_data_o` unchanged.
- Store, IDLE, legal:
  - `mem_req_o`=1, `mem_we_o`=1 for that cycle; memory writes at the next edge.
  - `lsu_stall_o`=0; state stays IDLE.
- Byte enables and write data for stores:
  - SB: `mem_be_o`=1<<addr[1:0]; `mem_wd_o`={4{data[7:0]}}.
  - SH: `mem_be_o`=addr[1]?4'b1100:4'b0011; `mem_wd_o`={2{data[15:0]}}.
  - SW: `mem_be_o`=4'b1111; `mem_wd_o`=data.
- Load, IDLE, legal:
  - `mem_req_o`=1, `mem_we_o`=0, `mem_be_o` as for the matching store size; `lsu_stall_o`=1.
  - At the edge, the extracted value is registered into `lsu_data_o`; state goes to RESP.
- Load extraction:
  - Shift `mem_rd_i` right by 8·addr[1:0].
  - B/H sign-extend bit 7/15; BU/HU zero-extend; W passes through.
- RESP:
  - `lsu_stall_o`=0 and `mem_req_o`=0; the request is not reissued even though `lsu_req_i` is still high.
  - Next state is IDLE unconditionally.
- `lsu_data_o` holds the last load result until the next legal load completes; stores and illegal requests do not change it.
- `lsu_req_i`=0: all `mem_*` outputs 0, `lsu_stall_o`=0, `lsu_misalign_o`=0.

## Timing
- Reset (async, any state):
  - State IDLE, `lsu_data_o`=0.
  - Combinational outputs follow IDLE rules, so they are 0 while `lsu_req_i`=0.
- Load latency: request in cycle T; stall high in T; data valid in T+1 with stall low; the core advances at the end of T+1.
- Store latency: 0 stall cycles; the write lands at the end of T.
- Back-to-back loads: the second request is seen in IDLE at T+2; there is no IDLE bubble beyond the RESP cycle.
- Reset asserted in T of a load: no data is captured; after release, `lsu_data_o`=0 and state is IDLE.
- `lsu_misalign_o`, `lsu_stall_o` and all `mem_*` outputs are combinational from inputs and state; `lsu_data_o` is registered.

## Test plan
- Reset → `lsu_data_o`=0, `lsu_stall_o`=0, `mem_req_o`=0.
- SB addr 0x06, data 0x000000A5 → `mem_addr_o`=0x04, `mem_be_o`=0100, `mem_wd_o`=0xA5A5A5A5, `mem_we_o`=1, stall 0.
- Memory word 0x80F0_1234 at 0x08:
  - LB addr 0x0B → stall 1 for one cycle, then `lsu_data_o`=0xFFFFFF80.
  - LBU addr 0x0B → 0x00000080.
  - LH addr 0x0A → 0xFFFF80F0.
  - LW addr 0x08 → 0x80F01234.
- LW addr 0x0A, or SH addr 0x03 → `lsu_misalign_o`=1, `mem_req_o`=0, stall 0, `lsu_data_o` unchanged.
- SW 0x12345678 to 0x10, then LW 0x10 → `lsu_data_o`=0x12345678 exactly one cycle after the load request; two consecutive loads show stall pattern 1,0,1,0.
- `arstn_i` pulsed low during the stall cycle of a load → state IDLE, `lsu_data_o`=0, no RESP cycle.
